// File: rtl/pattern_moore_param_if.sv
// Bit-stream, configuration and status bundle for the parametrised Moore pattern recognizer.
// The master side drives stream/config and observes status; the slave side is the detector.
interface pattern_moore_param_if #(
  parameter int PAT_W = 2,
  parameter int CNT_W = 8
) ();
  logic             en;
  logic             a;
  logic             cfg_load;
  logic [PAT_W-1:0] cfg_pattern;
  logic [PAT_W-1:0] cfg_mask;
  logic             cfg_overlap;
  logic             clear_count;
  logic             y;
  logic [CNT_W-1:0] match_count;
  logic             count_sat;

  modport master (
    output en, a, cfg_load, cfg_pattern, cfg_mask, cfg_overlap, clear_count,
    input  y, match_count, count_sat
  );

  modport slave (
    input  en, a, cfg_load, cfg_pattern, cfg_mask, cfg_overlap, clear_count,
    output y, match_count, count_sat
  );
endinterface

// File: rtl/pattern_moore_param.sv
// Moore serial pattern recognizer: programmable pattern/mask, overlap mode and a saturating
// match counter. Interface instance widths must agree with PAT_W / CNT_W.
//
//  state      | meaning
//  S_FILL     | fewer than PAT_W fresh bits accepted since load/reset/non-overlap hit
//  S_ARMED    | history full, last accepted bit did not complete a match
//  S_MATCHED  | last accepted bit completed a match (y = 1)
module pattern_moore_param #(
  parameter int               PAT_W       = 2,
  parameter int               CNT_W       = 8,
  parameter logic [PAT_W-1:0] DEF_PATTERN = PAT_W'(2'b01),
  parameter bit               DEF_OVERLAP = 1'b1
) (
  input logic                  clk,
  input logic                  reset,
  pattern_moore_param_if.slave bus
);
  localparam int               FILL_W  = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FULL   = FILL_W'(PAT_W);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  typedef enum logic [1:0] {S_FILL, S_ARMED, S_MATCHED} state_t;

  state_t            state;
  logic [PAT_W-1:0]  hist;
  logic [FILL_W-1:0] fill;
  logic [PAT_W-1:0]  pattern;
  logic [PAT_W-1:0]  mask;
  logic              overlap;
  logic              y_q;
  logic [CNT_W-1:0]  count;
  logic              sat;

  logic [PAT_W-1:0]  nh;
  logic [FILL_W-1:0] nf;
  logic              hit;

  always_comb begin
    nh  = {hist[PAT_W-2:0], bus.a};
    nf  = (fill == FULL) ? FULL : fill + FILL_W'(1);
    hit = bus.en && !bus.cfg_load && (nf == FULL) && (((nh ^ pattern) & mask) == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_FILL;
      hist    <= '0;
      fill    <= '0;
      pattern <= DEF_PATTERN;
      mask    <= '1;
      overlap <= DEF_OVERLAP;
      y_q     <= 1'b0;
      count   <= '0;
      sat     <= 1'b0;
    end else begin
      if (bus.cfg_load) begin
        pattern <= bus.cfg_pattern;
        mask    <= bus.cfg_mask;
        overlap <= bus.cfg_overlap;
        hist    <= '0;
        fill    <= '0;
        y_q     <= 1'b0;
        state   <= S_FILL;
      end else if (bus.en) begin
        hist <= nh;
        y_q  <= hit;
        // A non-overlapping hit discards the history so PAT_W fresh bits are needed
        fill <= (hit && !overlap) ? '0 : nf;
        if (hit)
          state <= S_MATCHED;
        else if (nf == FULL)
          state <= S_ARMED;
        else
          state <= S_FILL;
      end

      // Clear takes effect first; a hit on the same edge still counts
      if (bus.clear_count) begin
        count <= CNT_W'(hit);
        sat   <= 1'b0;
      end else if (hit) begin
        if (count == CNT_MAX) begin
          sat <= 1'b1;
        end else begin
          count <= count + CNT_W'(1);
          if (count == CNT_MAX - CNT_W'(1))
            sat <= 1'b1;
        end
      end
    end
  end

  assign bus.y           = y_q;
  assign bus.match_count = count;
  assign bus.count_sat   = sat;
endmodule

// File: tb/tb_pattern_moore_param.sv
// Scoreboard bench: two recognizer instances (default 2-bit, and 4-bit with a 2-bit counter)
// share one scalar stimulus stream; a queue-based reference model predicts every cycle.
module tb_pattern_moore_param;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pattern_moore_param_if #(.PAT_W(2), .CNT_W(8)) if2 ();
  pattern_moore_param_if #(.PAT_W(4), .CNT_W(2)) if4 ();

  pattern_moore_param u_def (.clk(clk), .reset(reset), .bus(if2));

  pattern_moore_param #(
    .PAT_W(4), .CNT_W(2), .DEF_PATTERN(4'b1011), .DEF_OVERLAP(1'b0)
  ) u_p4 (.clk(clk), .reset(reset), .bus(if4));

  // stimulus
  bit       r, e, b, ld, clr;
  bit [1:0] p2, m2;
  bit [3:0] p4, m4;
  bit       o2, o4;

  // reference model, index 0 = u_def, 1 = u_p4
  int        pw [2] = '{2, 4};
  int        cmax [2] = '{255, 3};
  bit [31:0] defp [2] = '{32'b01, 32'b1011};
  bit        defo [2] = '{1'b1, 1'b0};
  bit [31:0] pat [2], msk [2];
  bit        ovl [2], my [2], msat [2];
  int        mcnt [2];
  bit        hq [2][$];

  typedef struct {
    bit y0; int c0; bit s0;
    bit y1; int c1; bit s1;
  } exp_t;
  exp_t sq[$];

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(int k, bit [31:0] p, bit [31:0] m, bit o);
    bit hit;
    hit = 1'b0;
    if (r) begin
      hq[k].delete();
      pat[k] = defp[k]; msk[k] = (32'h1 << pw[k]) - 1; ovl[k] = defo[k];
      my[k] = 1'b0; mcnt[k] = 0; msat[k] = 1'b0;
      return;
    end
    if (ld) begin
      pat[k] = p; msk[k] = m; ovl[k] = o;
      hq[k].delete();
      my[k] = 1'b0;
    end else if (e) begin
      hq[k].push_back(b);
      if (hq[k].size() > pw[k]) void'(hq[k].pop_front());
      hit = (hq[k].size() == pw[k]);
      for (int i = 0; i < pw[k]; i++)
        if (msk[k][pw[k]-1-i] && hq[k][i] != pat[k][pw[k]-1-i]) hit = 1'b0;
      my[k] = hit;
      if (hit && !ovl[k]) hq[k].delete();
    end
    if (clr) begin
      mcnt[k] = hit ? 1 : 0;
      msat[k] = 1'b0;
    end else if (hit) begin
      if (mcnt[k] == cmax[k]) msat[k] = 1'b1;
      else begin
        mcnt[k]++;
        if (mcnt[k] == cmax[k]) msat[k] = 1'b1;
      end
    end
  endtask

  // inputs change at the negedge; the model advances at the posedge the DUT samples them
  task automatic tick();
    exp_t ex;
    reset = r;
    if2.en = e; if2.a = b; if2.cfg_load = ld; if2.clear_count = clr;
    if2.cfg_pattern = p2; if2.cfg_mask = m2; if2.cfg_overlap = o2;
    if4.en = e; if4.a = b; if4.cfg_load = ld; if4.clear_count = clr;
    if4.cfg_pattern = p4; if4.cfg_mask = m4; if4.cfg_overlap = o4;
    @(posedge clk);
    model_step(0, {30'b0, p2}, {30'b0, m2}, o2);
    model_step(1, {28'b0, p4}, {28'b0, m4}, o4);
    ex.y0 = my[0]; ex.c0 = mcnt[0]; ex.s0 = msat[0];
    ex.y1 = my[1]; ex.c1 = mcnt[1]; ex.s1 = msat[1];
    sq.push_back(ex);
    @(negedge clk);
  endtask

  task automatic do_reset();
    r = 1'b1; e = 1'b0; ld = 1'b0; clr = 1'b0;
    tick();
    r = 1'b0;
  endtask

  task automatic send(bit [31:0] v, int n);
    for (int i = n - 1; i >= 0; i--) begin
      e = 1'b1; b = v[i];
      tick();
    end
    e = 1'b0;
  endtask

  task automatic load(bit [1:0] pp2, bit [1:0] mm2, bit oo2, bit [3:0] pp4, bit [3:0] mm4, bit oo4);
    p2 = pp2; m2 = mm2; o2 = oo2; p4 = pp4; m4 = mm4; o4 = oo4;
    ld = 1'b1;
    tick();
    ld = 1'b0;
  endtask

  task automatic idle(int n);
    e = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  // monitor: every cycle presents a status word, compared against the oldest prediction
  initial begin
    exp_t ex;
    forever begin
      @(negedge clk);
      while (sq.size() > 0) begin
        ex = sq.pop_front();
        chk("y_def",   32'(if2.y),           32'(ex.y0));
        chk("cnt_def", 32'(if2.match_count), ex.c0);
        chk("sat_def", 32'(if2.count_sat),   32'(ex.s0));
        chk("y_p4",    32'(if4.y),           32'(ex.y1));
        chk("cnt_p4",  32'(if4.match_count), ex.c1);
        chk("sat_p4",  32'(if4.count_sat),   32'(ex.s1));
      end
    end
  end

  initial begin
    r = 1'b1; e = 1'b0; b = 1'b0; ld = 1'b0; clr = 1'b0;
    p2 = '0; m2 = '1; o2 = 1'b1; p4 = '0; m4 = '1; o4 = 1'b1;
    @(negedge clk);

    // defaults: 0,1,1,0,1 -> hits on bits 2 and 5
    do_reset();
    chk("t1_reset_cnt", 32'(if2.match_count), 0);
    send(32'b01101, 5);
    chk("t1_count", 32'(if2.match_count), 2);

    // 4-bit 1011, overlapping then non-overlapping
    do_reset();
    load(2'b01, 2'b11, 1'b1, 4'b1011, 4'b1111, 1'b1);
    send(32'b1011011, 7);
    chk("t2_ovl_count", 32'(if4.match_count), 2);
    do_reset();
    load(2'b01, 2'b11, 1'b1, 4'b1011, 4'b1111, 1'b0);
    send(32'b1011011, 7);
    chk("t2_novl_count", 32'(if4.match_count), 1);

    // masked pattern, then all don't-care
    do_reset();
    load(2'b01, 2'b11, 1'b1, 4'b1001, 4'b1001, 1'b0);
    send(32'b11011000, 8);
    chk("t3_mask_count", 32'(if4.match_count), 1);
    load(2'b01, 2'b00, 1'b1, 4'b0000, 4'b0000, 1'b1);
    send(32'b000, 3);
    chk("t3_m0_nohit", 32'(if4.y), 0);
    send(32'b1, 1);
    chk("t3_m0_hit", 32'(if4.y), 1);

    // saturation of the 2-bit counter, then clear concurrent with a hit
    send(32'b010, 3);
    chk("t4_sat_count", 32'(if4.match_count), 3);
    chk("t4_sat_flag", 32'(if4.count_sat), 1);
    clr = 1'b1;
    send(32'b1, 1);
    clr = 1'b0;
    chk("t4_clr_count", 32'(if4.match_count), 1);
    chk("t4_clr_sat", 32'(if4.count_sat), 0);

    // enable gaps
    do_reset();
    send(32'b0, 1);
    idle(3);
    send(32'b1, 1);
    chk("t5_gap_hit", 32'(if2.y), 1);
    idle(3);
    chk("t5_hold", 32'(if2.y), 1);

    // load mid-pattern flushes; reset restores the default pattern
    do_reset();
    send(32'b0, 1);
    load(2'b01, 2'b11, 1'b1, 4'b1011, 4'b1111, 1'b1);
    send(32'b1, 1);
    chk("t6_flush", 32'(if2.y), 0);
    load(2'b10, 2'b11, 1'b1, 4'b0000, 4'b1111, 1'b1);
    send(32'b10, 2);
    do_reset();
    chk("t6_rst_y", 32'(if2.y), 0);
    chk("t6_rst_cnt", 32'(if2.match_count), 0);
    send(32'b01, 2);
    chk("t6_default_pat", 32'(if2.y), 1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r   = ($urandom_range(0, 199) == 0);
      ld  = !r && ($urandom_range(0, 49) == 0);
      clr = !r && ($urandom_range(0, 49) == 0);
      e   = ($urandom_range(0, 3) != 0);
      b   = $urandom_range(0, 1);
      if (ld) begin
        p2 = 2'($urandom); m2 = 2'($urandom | $urandom); o2 = $urandom_range(0, 1);
        p4 = 4'($urandom); m4 = 4'($urandom | $urandom); o4 = $urandom_range(0, 1);
      end
      tick();
    end
    r = 1'b0; ld = 1'b0; clr = 1'b0; e = 1'b0;

    @(posedge clk);
    @(negedge clk);
    #1;
    if (sq.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain: %0d predictions left, expected 0", sq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
